// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch slice: default widths and
// the fetch FSM state encoding.
package cpu_pkg;

    localparam int ADDR_WIDTH_DEF = 3;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_LO   = 3'd1,
        ST_RD_HI   = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_VALID   = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's request/response handshake and its byte-wide
// instruction memory port. master = fetch unit side, slave = environment.
interface instr_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                      fetch_req;
    logic                      jump_en;
    logic [ADDR_WIDTH-1:0]     jump_target;
    logic                      instr_ready;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_rd_en;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic [2*DATA_WIDTH-1:0]   instr;
    logic                      instr_valid;
    logic [ADDR_WIDTH-1:0]     pc;
    logic                      busy;

    modport master (
        input  fetch_req,
        input  jump_en,
        input  jump_target,
        input  instr_ready,
        input  mem_rdata,
        output mem_addr,
        output mem_rd_en,
        output instr,
        output instr_valid,
        output pc,
        output busy
    );

    modport slave (
        output fetch_req,
        output jump_en,
        output jump_target,
        output instr_ready,
        output mem_rdata,
        input  mem_addr,
        input  mem_rd_en,
        input  instr,
        input  instr_valid,
        input  pc,
        input  busy
    );

endinterface

// File: rtl/fetch_pc.sv
// Program counter: loads a jump target, advances by one instruction (two
// bytes) on accept, and supplies the wrapped address of the high byte.
module fetch_pc
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus1
);

    // Arithmetic is kept at ADDR_WIDTH bits so it wraps modulo memory size.
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

    assign pc_plus1 = pc + ONE;

    // Jump has priority over the post-accept increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (jump_en) begin
            pc <= jump_target;
        end else if (advance) begin
            pc <= pc + TWO;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads two consecutive bytes from a byte-wide
// memory with one-cycle read latency and presents them as one instruction
// with a valid/ready handshake. Jumps abort any fetch in progress.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    fetch_state_e              state;
    logic [2*DATA_WIDTH-1:0]   instr;
    logic                      instr_valid;
    logic [ADDR_WIDTH-1:0]     pc;
    logic [ADDR_WIDTH-1:0]     pc_plus1;
    logic                      accept;
    logic                      mem_rd_en;
    logic [ADDR_WIDTH-1:0]     mem_addr;

    assign accept = (state == ST_VALID) && bus.instr_ready;

    fetch_pc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fetch_pc (
        .clk         (clk),
        .rst         (rst),
        .jump_en     (bus.jump_en),
        .jump_target (bus.jump_target),
        .advance     (accept),
        .pc          (pc),
        .pc_plus1    (pc_plus1)
    );

    // Sequencing and byte assembly. Read data for an address issued in one
    // state arrives in the following state, so the low byte is captured at
    // the end of RD_HI and the high byte at the end of RD_WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (bus.jump_en) begin
            state       <= ST_IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.fetch_req) begin
                        state <= ST_RD_LO;
                    end
                end
                ST_RD_LO: begin
                    state <= ST_RD_HI;
                end
                ST_RD_HI: begin
                    instr[DATA_WIDTH-1:0] <= bus.mem_rdata;
                    state                 <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    instr[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.mem_rdata;
                    instr_valid                      <= 1'b1;
                    state                            <= ST_VALID;
                end
                ST_VALID: begin
                    if (bus.instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= bus.fetch_req ? ST_RD_LO : ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Memory port is decoded from state and pc only; it idles at pc.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = pc;
        case (state)
            ST_RD_LO: begin
                mem_rd_en = 1'b1;
                mem_addr  = pc;
            end
            ST_RD_HI: begin
                mem_rd_en = 1'b1;
                mem_addr  = pc_plus1;
            end
            default: begin
                mem_rd_en = 1'b0;
                mem_addr  = pc;
            end
        endcase
    end

    assign bus.mem_rd_en   = mem_rd_en;
    assign bus.mem_addr    = mem_addr;
    assign bus.instr       = instr;
    assign bus.instr_valid = instr_valid;
    assign bus.pc          = pc;
    assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small byte memory model that
// returns data one cycle after each read strobe.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int AW = ADDR_WIDTH_DEF;
    localparam int DW = DATA_WIDTH_DEF;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem [0:(2**AW)-1];

    instr_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency.
    always_ff @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starting from IDLE: pulse fetch_req, wait three more edges, check result.
    task automatic fetch_expect(input string tag, input logic [31:0] exp_instr);
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        tick();
        tick();
        tick();
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'h1);
        check({tag, "_instr"}, 32'(bus.instr), exp_instr);
    endtask

    initial begin
        logic [31:0] v2_exp [5];
        logic [31:0] v2_pc [5];
        v2_exp = '{32'h2214, 32'h4F31, 32'h6055, 32'h8B7A, 32'h2214};
        v2_pc  = '{32'h2, 32'h4, 32'h6, 32'h0, 32'h2};

        mem[0] = 8'h14; mem[1] = 8'h22; mem[2] = 8'h31; mem[3] = 8'h4F;
        mem[4] = 8'h55; mem[5] = 8'h60; mem[6] = 8'h7A; mem[7] = 8'h8B;

        bus.fetch_req   = 1'b0;
        bus.jump_en     = 1'b0;
        bus.jump_target = '0;
        bus.instr_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_rd_en", 32'(bus.mem_rd_en), 32'h0);
        check("rst_instr", 32'(bus.instr), 32'h0);
        rst = 1'b1;

        // V1: single fetch, address sequence 0,1, latency 3 edges
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        check("v1_lo_rd_en", 32'(bus.mem_rd_en), 32'h1);
        check("v1_lo_addr", 32'(bus.mem_addr), 32'h0);
        check("v1_lo_busy", 32'(bus.busy), 32'h1);
        tick();
        check("v1_hi_rd_en", 32'(bus.mem_rd_en), 32'h1);
        check("v1_hi_addr", 32'(bus.mem_addr), 32'h1);
        tick();
        check("v1_wait_rd_en", 32'(bus.mem_rd_en), 32'h0);
        check("v1_wait_valid", 32'(bus.instr_valid), 32'h0);
        tick();
        check("v1_valid", 32'(bus.instr_valid), 32'h1);
        check("v1_instr", 32'(bus.instr), 32'h2214);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("v1_acc_pc", 32'(bus.pc), 32'h2);
        check("v1_acc_valid", 32'(bus.instr_valid), 32'h0);
        check("v1_acc_busy", 32'(bus.busy), 32'h0);

        // V2: back-to-back fetches with pc wrap, starting from pc=0
        bus.jump_en = 1'b1;
        bus.jump_target = '0;
        tick();
        bus.jump_en = 1'b0;
        check("v2_jump_pc", 32'(bus.pc), 32'h0);
        bus.fetch_req = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            tick();
            check($sformatf("v2_valid_%0d", i), 32'(bus.instr_valid), 32'h1);
            check($sformatf("v2_instr_%0d", i), 32'(bus.instr), v2_exp[i]);
            if (i == 4) bus.fetch_req = 1'b0;
            tick();
            check($sformatf("v2_pc_%0d", i), 32'(bus.pc), v2_pc[i]);
        end
        bus.instr_ready = 1'b0;
        check("v2_end_busy", 32'(bus.busy), 32'h0);

        // V3: jump to 7, high byte wraps to address 0
        bus.jump_en = 1'b1;
        bus.jump_target = AW'(7);
        tick();
        bus.jump_en = 1'b0;
        check("v3_pc", 32'(bus.pc), 32'h7);
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        check("v3_lo_addr", 32'(bus.mem_addr), 32'h7);
        tick();
        check("v3_hi_addr", 32'(bus.mem_addr), 32'h0);
        tick();
        tick();
        check("v3_valid", 32'(bus.instr_valid), 32'h1);
        check("v3_instr", 32'(bus.instr), 32'h148B);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("v3_acc_pc", 32'(bus.pc), 32'h1);

        // V4: jump in RD_HI to 4 (with ready/fetch_req also high) aborts fetch
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        tick();
        check("v4_in_hi_addr", 32'(bus.mem_addr), 32'h2);
        bus.jump_en = 1'b1;
        bus.jump_target = AW'(4);
        bus.fetch_req = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        bus.jump_en = 1'b0;
        bus.fetch_req = 1'b0;
        bus.instr_ready = 1'b0;
        check("v4_busy", 32'(bus.busy), 32'h0);
        check("v4_valid", 32'(bus.instr_valid), 32'h0);
        check("v4_pc", 32'(bus.pc), 32'h4);
        check("v4_rd_en", 32'(bus.mem_rd_en), 32'h0);
        tick();
        check("v4_idle_valid", 32'(bus.instr_valid), 32'h0);
        fetch_expect("v4", 32'h6055);

        // V5: stall in VALID for 5 cycles, then accept
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("v5_valid_%0d", i), 32'(bus.instr_valid), 32'h1);
            check($sformatf("v5_instr_%0d", i), 32'(bus.instr), 32'h6055);
            check($sformatf("v5_pc_%0d", i), 32'(bus.pc), 32'h4);
            check($sformatf("v5_rd_en_%0d", i), 32'(bus.mem_rd_en), 32'h0);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("v5_acc_pc", 32'(bus.pc), 32'h6);
        check("v5_acc_valid", 32'(bus.instr_valid), 32'h0);

        // Jump beats accept in VALID: no +2 increment
        fetch_expect("prio", 32'h8B7A);
        bus.jump_en = 1'b1;
        bus.jump_target = AW'(3);
        bus.instr_ready = 1'b1;
        bus.fetch_req = 1'b1;
        tick();
        bus.jump_en = 1'b0;
        bus.instr_ready = 1'b0;
        bus.fetch_req = 1'b0;
        check("prio_pc", 32'(bus.pc), 32'h3);
        check("prio_busy", 32'(bus.busy), 32'h0);
        check("prio_valid", 32'(bus.instr_valid), 32'h0);

        // V6: asynchronous reset during RD_WAIT
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        tick();
        tick();
        check("v6_pre_busy", 32'(bus.busy), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("v6_pc", 32'(bus.pc), 32'h0);
        check("v6_busy", 32'(bus.busy), 32'h0);
        check("v6_valid", 32'(bus.instr_valid), 32'h0);
        check("v6_rd_en", 32'(bus.mem_rd_en), 32'h0);
        check("v6_instr", 32'(bus.instr), 32'h0);
        check("v6_addr", 32'(bus.mem_addr), 32'h0);
        bus.fetch_req = 1'b1;
        tick();
        check("v6_held_busy", 32'(bus.busy), 32'h0);
        bus.fetch_req = 1'b0;
        rst = 1'b1;
        fetch_expect("v6", 32'h2214);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
